// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset constants, opcodes and fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPC_W = 7;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [OPC_W-1:0] OP_R = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[OPC_W-1:0];
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory req/ack handshake between the fetch unit (master) and memory (slave).
interface ifetch_unit_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [ILEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/ifetch_pc_reg.sv
// PC register: reset value, target load, +4 advance and misaligned-target handling.
// Alignment behaviour selected by IFETCH_ALIGN_CHECK_EN (fault+hold when defined, truncate otherwise).
module ifetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_data,
    input  logic            inc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_c,
    output logic            align_fault
);

    logic            load_ok_c;
    logic [XLEN-1:0] target_c;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign load_ok_c = load && (load_data[1:0] == 2'b00);
    assign target_c  = load_data;

    // Sticky until reset; a rejected target leaves the PC untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_fault <= 1'b0;
        end else if (load && (load_data[1:0] != 2'b00)) begin
            align_fault <= 1'b1;
        end
    end
`else
    assign load_ok_c   = load;
    assign target_c    = load_data & ~(XLEN'(2'b11));
    assign align_fault = 1'b0;
`endif

    // Advance and load never coincide: load is only offered while idle.
    always_comb begin
        pc_next_c = pc;
        if (inc) begin
            pc_next_c = pc + XLEN'(4);
        end else if (load_ok_c) begin
            pc_next_c = target_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns PC/IR, fetches one word per request over the imem handshake.
// Optional target alignment checking via IFETCH_ALIGN_CHECK_EN (see ifetch_pc_reg).
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_wr,
    input  logic [XLEN-1:0]   pc_wdata,
    ifetch_unit_if.master     imem,
    output logic [XLEN-1:0]   pc,
    output logic [ILEN-1:0]   ir,
    output logic [OPC_W-1:0]  opcode,
    output logic              busy,
    output logic              fetch_done,
    output logic              align_fault
);

    fetch_state_e    state;
    logic            pc_load_c;
    logic            pc_inc_c;
    logic [XLEN-1:0] pc_next_c;

    assign pc_load_c = (state == FETCH_IDLE) && pc_wr;
    assign pc_inc_c  = (state == FETCH_WAIT) && imem.ack;
    assign opcode    = opcode_of(ir);

    ifetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (pc_load_c),
        .load_data   (pc_wdata),
        .inc         (pc_inc_c),
        .pc          (pc),
        .pc_next_c   (pc_next_c),
        .align_fault (align_fault)
    );

    // Fetch FSM; the request address is the PC as it stands after any same-cycle target load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_IDLE;
            ir         <= NOP_INSTR;
            imem.req   <= 1'b0;
            imem.addr  <= RESET_PC;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (fetch_start) begin
                        state     <= FETCH_WAIT;
                        imem.req  <= 1'b1;
                        imem.addr <= pc_next_c;
                        busy      <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (imem.ack) begin
                        state      <= FETCH_DONE;
                        ir         <= imem.rdata;
                        imem.req   <= 1'b0;
                        fetch_done <= 1'b1;
                    end
                end
                FETCH_DONE: begin
                    state <= FETCH_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem.req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table of fetches, scoreboard on fetch_done, reset/ack corners.
module tb_ifetch_unit;
    import riscv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_start;
    logic              pc_wr;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   pc;
    logic [ILEN-1:0]   ir;
    logic [OPC_W-1:0]  opcode;
    logic              busy;
    logic              fetch_done;
    logic              align_fault;

    ifetch_unit_if imem_bus ();

    ifetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_wr       (pc_wr),
        .pc_wdata    (pc_wdata),
        .imem        (imem_bus),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .align_fault (align_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_wr;
        logic [31:0] wdata;
        int          delay;
        logic        noise;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    localparam logic [31:0] NOISE_ADDR = 32'hDEAD_0000;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every fetch_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && fetch_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_fetch_done", 32'(fetch_done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_ir", ir, e.ir);
                check("sb_pc", pc, e.pc);
                check("sb_opcode", 32'(opcode), 32'(e.ir[6:0]));
            end
        end
    end

    task automatic do_fetch(input vec_t v, input string tag);
        logic [31:0] ir_before;
        int          req_cycles;
        logic        addr_ok;
        logic        ir_ok;
        @(negedge clk);
        fetch_start = 1'b1;
        pc_wr       = v.pc_wr;
        pc_wdata    = v.wdata;
        exp_q.push_back('{ir: v.rdata, pc: v.exp_pc});
        @(negedge clk);
        fetch_start = v.noise;
        pc_wr       = v.noise;
        pc_wdata    = NOISE_ADDR;
        ir_before   = ir;
        req_cycles  = 0;
        addr_ok     = 1'b1;
        ir_ok       = 1'b1;
        check({tag, "_busy_wait"}, 32'(busy), 32'd1);
        for (int c = 0; c <= v.delay; c++) begin
            if (imem_bus.req === 1'b1) req_cycles++;
            if (imem_bus.addr !== v.exp_addr) addr_ok = 1'b0;
            if (ir !== ir_before) ir_ok = 1'b0;
            if (c == v.delay) begin
                imem_bus.ack   = 1'b1;
                imem_bus.rdata = v.rdata;
            end else begin
                imem_bus.rdata = 32'hBAD0_0000 | 32'(c);
            end
            @(negedge clk);
        end
        imem_bus.ack = 1'b0;
        check({tag, "_req_cycles"}, 32'(req_cycles), 32'(v.delay + 1));
        check({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
        check({tag, "_ir_held"}, 32'(ir_ok), 32'd1);
        check({tag, "_done_latency"}, 32'(fetch_done), 32'd1);
        check({tag, "_req_dropped"}, 32'(imem_bus.req), 32'd0);
        @(negedge clk);
        fetch_start = 1'b0;
        pc_wr       = 1'b0;
        pc_wdata    = '0;
        check({tag, "_done_pulse"}, 32'(fetch_done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // {pc_wr, wdata, delay, noise, rdata, exp_addr, exp_pc}
        vecs[0] = '{1'b0, 32'h0,         0, 1'b0, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{1'b0, 32'h0,         3, 1'b0, 32'h0020_81B3, 32'h0000_0004, 32'h0000_0008};
        vecs[2] = '{1'b1, 32'h100,       1, 1'b0, 32'h4000_0033, 32'h0000_0100, 32'h0000_0104};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 2, 1'b1, 32'h00A0_0113, 32'hFFFF_FFFC, 32'h0000_0000};
`ifdef IFETCH_ALIGN_CHECK_EN
        vecs[4] = '{1'b1, 32'h102,       0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0004};
        vecs[5] = '{1'b0, 32'h0,         1, 1'b0, 32'h0000_0013, 32'h0000_0004, 32'h0000_0008};
`else
        vecs[4] = '{1'b1, 32'h102,       0, 1'b0, 32'h1234_5678, 32'h0000_0100, 32'h0000_0104};
        vecs[5] = '{1'b0, 32'h0,         1, 1'b0, 32'h0000_0013, 32'h0000_0104, 32'h0000_0108};
`endif

        reset          = 1'b1;
        fetch_start    = 1'b0;
        pc_wr          = 1'b0;
        pc_wdata       = '0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_opcode", 32'(opcode), 32'(OP_I));
        check("rst_req", 32'(imem_bus.req), 32'd0);
        check("rst_addr", imem_bus.addr, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_align", 32'(align_fault), 32'd0);

        // Stray ack with no request outstanding.
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        imem_bus.ack = 1'b0;
        check("stray_ack_ir", ir, 32'h0000_0013);
        check("stray_ack_req", 32'(imem_bus.req), 32'd0);
        check("stray_ack_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i], $sformatf("v%0d", i));
            if (i == 0) check("v0_opcode_i", 32'(opcode), 32'(OP_I));
            if (i == 1) check("v1_opcode_r", 32'(opcode), 32'(OP_R));
            if (i == 3) check("v3_wrap_pc", pc, 32'h0);
            if (i == 4) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                check("v4_align_fault", 32'(align_fault), 32'd1);
`else
                check("v4_align_fault", 32'(align_fault), 32'd0);
`endif
            end
        end

        // Reset while waiting for memory, then a late ack.
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("rmid_req_up", 32'(imem_bus.req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hFFFF_FFFF;
        check("rmid_req", 32'(imem_bus.req), 32'd0);
        check("rmid_ir", ir, 32'h0000_0013);
        check("rmid_pc", pc, 32'h0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_align", 32'(align_fault), 32'd0);
        @(negedge clk);
        imem_bus.ack = 1'b0;
        check("rmid_no_done", 32'(fetch_done), 32'd0);
        check("rmid_ir_late", ir, 32'h0000_0013);
        check("rmid_pc_late", pc, 32'h0);
        repeat (2) @(negedge clk);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'd6);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
